// File: rtl/pkg_busca.sv
// Shared types and constants for the instruction-fetch stage.
package pkg_busca;

  typedef enum logic [1:0] {
    INICIO,
    BUSCA,
    FIM
  } estado_t;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam int unsigned PALAVRA_BYTES = 4;

endpackage

// File: rtl/reg_if_id.sv
// IF/ID pipeline register: flush has priority over load, otherwise hold.
module reg_if_id
  import pkg_busca::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        carrega,
  input  logic        limpa,
  input  logic [31:0] instrucao_d,
  input  logic [31:0] pc_mais4_d,
  output logic [31:0] instrucao,
  output logic [31:0] pc_mais4,
  output logic        valido
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instrucao <= NOP;
      pc_mais4  <= 32'h0;
      valido    <= 1'b0;
    end else if (limpa) begin
      instrucao <= NOP;
      pc_mais4  <= 32'h0;
      valido    <= 1'b0;
    end else if (carrega) begin
      instrucao <= instrucao_d;
      pc_mais4  <= pc_mais4_d;
      valido    <= 1'b1;
    end
  end

endmodule

// File: rtl/estagio_busca.sv
// Instruction-fetch stage: PC, fetch FSM and IF/ID register.
// Optional macro CONTADOR_BUSCA_EN adds the saturating num_buscas fetch counter.
module estagio_busca
  import pkg_busca::*;
#(
  parameter logic [31:0] PC_INICIAL      = 32'h0000_0000,
  parameter int unsigned MEMORIA_TAMANHO = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redireciona,
  input  logic [31:0] endereco_alvo,
  input  logic [31:0] instrucao_in,
  output logic [31:0] pc_out,
  output logic [31:0] if_id_instrucao,
  output logic [31:0] if_id_pc_mais4,
  output logic        if_id_valido,
  output logic        parado,
  output logic        erro_alinhamento
`ifdef CONTADOR_BUSCA_EN
  ,
  output logic [31:0] num_buscas
`endif
);

  localparam logic [31:0] LIMITE = 32'(MEMORIA_TAMANHO * PALAVRA_BYTES);
  localparam logic [31:0] ULTIMO = LIMITE - 32'(PALAVRA_BYTES);

  estado_t     estado, estado_prox;
  logic [31:0] pc_prox;
  logic [31:0] pc_seguinte;
  logic        erro_prox;
  logic        carrega;
  logic        limpa;

  assign pc_seguinte = pc_out + 32'(PALAVRA_BYTES);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado           <= INICIO;
      pc_out           <= PC_INICIAL;
      erro_alinhamento <= 1'b0;
      parado           <= 1'b0;
    end else begin
      estado           <= estado_prox;
      pc_out           <= pc_prox;
      erro_alinhamento <= erro_prox;
      parado           <= (estado_prox == FIM);
    end
  end

  // Redirect overrides everything; stall only matters during normal fetch.
  always_comb begin
    estado_prox = estado;
    pc_prox     = pc_out;
    erro_prox   = erro_alinhamento;
    carrega     = 1'b0;
    limpa       = 1'b0;
    if (redireciona) begin
      limpa = 1'b1;
      if (endereco_alvo[1:0] != 2'b00) begin
        erro_prox   = 1'b1;
        estado_prox = FIM;
      end else if (endereco_alvo >= LIMITE) begin
        pc_prox     = endereco_alvo;
        estado_prox = FIM;
      end else begin
        pc_prox     = endereco_alvo;
        estado_prox = BUSCA;
      end
    end else begin
      unique case (estado)
        INICIO: begin
          limpa       = 1'b1;
          estado_prox = BUSCA;
        end
        BUSCA: begin
          if (!stall) begin
            carrega = 1'b1;
            if (pc_out == ULTIMO) begin
              pc_prox     = 32'h0;
              estado_prox = FIM;
            end else begin
              pc_prox = pc_seguinte;
            end
          end
        end
        FIM: limpa = 1'b1;
        default: begin
          limpa       = 1'b1;
          estado_prox = INICIO;
        end
      endcase
    end
  end

  reg_if_id u_reg_if_id (
    .clock      (clock),
    .reset      (reset),
    .carrega    (carrega),
    .limpa      (limpa),
    .instrucao_d(instrucao_in),
    .pc_mais4_d (pc_seguinte),
    .instrucao  (if_id_instrucao),
    .pc_mais4   (if_id_pc_mais4),
    .valido     (if_id_valido)
  );

`ifdef CONTADOR_BUSCA_EN
  // Counts valid IF/ID latches, saturating at all-ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      num_buscas <= 32'h0;
    end else if (carrega && (num_buscas != 32'hFFFF_FFFF)) begin
      num_buscas <= num_buscas + 32'h1;
    end
  end
`endif

endmodule

// File: tb/tb_estagio_busca.sv
// Self-checking bench for estagio_busca: directed scenarios plus random
// stall/redirect traffic checked against a behavioural fetch model.
module tb_estagio_busca;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        redireciona;
  logic [31:0] endereco_alvo;
  logic [31:0] instrucao_in;
  logic [31:0] pc_out;
  logic [31:0] if_id_instrucao;
  logic [31:0] if_id_pc_mais4;
  logic        if_id_valido;
  logic        parado;
  logic        erro_alinhamento;
`ifdef CONTADOR_BUSCA_EN
  logic [31:0] num_buscas;
`endif

  logic [31:0] rom [256];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pm4, m_cnt;
  logic        m_val, m_par, m_err, m_bolha;

  estagio_busca dut (
    .clock           (clock),
    .reset           (reset),
    .stall           (stall),
    .redireciona     (redireciona),
    .endereco_alvo   (endereco_alvo),
    .instrucao_in    (instrucao_in),
    .pc_out          (pc_out),
    .if_id_instrucao (if_id_instrucao),
    .if_id_pc_mais4  (if_id_pc_mais4),
    .if_id_valido    (if_id_valido),
    .parado          (parado),
    .erro_alinhamento(erro_alinhamento)
`ifdef CONTADOR_BUSCA_EN
    ,
    .num_buscas      (num_buscas)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb instrucao_in = (pc_out < 32'd1024) ? rom[pc_out[9:2]] : 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic confere(input string ctx);
    chk({ctx, ".pc_out"}, pc_out, m_pc);
    chk({ctx, ".instrucao"}, if_id_instrucao, m_instr);
    chk({ctx, ".pc_mais4"}, if_id_pc_mais4, m_pm4);
    chk({ctx, ".valido"}, 32'(if_id_valido), 32'(m_val));
    chk({ctx, ".parado"}, 32'(parado), 32'(m_par));
    chk({ctx, ".erro"}, 32'(erro_alinhamento), 32'(m_err));
`ifdef CONTADOR_BUSCA_EN
    chk({ctx, ".num_buscas"}, num_buscas, m_cnt);
`endif
  endtask

  task automatic modelo_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pm4 = 32'h0; m_cnt = 32'h0;
    m_val = 1'b0; m_par = 1'b0; m_err = 1'b0; m_bolha = 1'b1;
  endtask

  // Effect of one clock edge given the inputs presented before it.
  task automatic modelo(input logic st, input logic rd, input logic [31:0] alvo);
    if (rd) begin
      m_instr = 32'h0; m_pm4 = 32'h0; m_val = 1'b0; m_bolha = 1'b0;
      if (alvo % 4 != 0) begin
        m_err = 1'b1; m_par = 1'b1;
      end else begin
        m_pc  = alvo;
        m_par = (alvo >= 32'd1024);
      end
    end else if (m_bolha) begin
      m_bolha = 1'b0;
      m_instr = 32'h0; m_pm4 = 32'h0; m_val = 1'b0;
    end else if (m_par) begin
      m_instr = 32'h0; m_pm4 = 32'h0; m_val = 1'b0;
    end else if (!st) begin
      m_instr = rom[m_pc / 4];
      m_pm4   = m_pc + 32'd4;
      m_val   = 1'b1;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      if (m_pc + 32'd4 == 32'd1024) begin
        m_pc = 32'h0; m_par = 1'b1;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic passo(input string ctx, input logic st, input logic rd, input logic [31:0] alvo);
    stall = st; redireciona = rd; endereco_alvo = alvo;
    modelo(st, rd, alvo);
    @(posedge clock);
    #1;
    confere(ctx);
  endtask

  initial begin
    logic [31:0] alvo;
    int          tipo;
    for (int i = 0; i < 256; i++) rom[i] = $urandom;
    rom[0] = 32'h2008_0005;
    stall = 1'b0; redireciona = 1'b0; endereco_alvo = 32'h0;
    reset = 1'b1;
    modelo_reset();
    repeat (2) @(posedge clock);
    #1;
    confere("reset");
    @(negedge clock);
    reset = 1'b0;

    // Bubble then first fetch
    passo("inicio", 1'b0, 1'b0, 32'h0);
    passo("fetch0", 1'b0, 1'b0, 32'h0);
    chk("fetch0.word", if_id_instrucao, 32'h2008_0005);
    passo("fetch1", 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) passo("stall", 1'b1, 1'b0, 32'h0);
    passo("resume", 1'b0, 1'b0, 32'h0);
    chk("resume.pc12", pc_out, 32'd12);

    // Redirect beats stall
    passo("redir_stall", 1'b1, 1'b1, 32'h40);
    passo("word16", 1'b0, 1'b0, 32'h0);

    // Misaligned target halts with sticky error, valid redirect resumes
    passo("desalinhado", 1'b0, 1'b1, 32'h42);
    passo("fim_hold", 1'b1, 1'b0, 32'h0);
    passo("fim_hold2", 1'b0, 1'b0, 32'h0);
    passo("sai_fim", 1'b0, 1'b1, 32'h10);
    passo("apos_fim", 1'b0, 1'b0, 32'h0);

    // Out-of-range target halts without error
    passo("fora", 1'b0, 1'b1, 32'h400);
    passo("fora_hold", 1'b0, 1'b0, 32'h0);

    // Run off the end of memory
    passo("fim_mem0", 1'b0, 1'b1, 32'h3F8);
    for (int i = 0; i < 5; i++) passo("fim_mem", 1'b0, 1'b0, 32'h0);
    chk("fim_mem.pc0", pc_out, 32'h0);

    // Random traffic
    passo("rand0", 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 600; i++) begin
      logic st, rd;
      st = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 15) == 0);
      tipo = $urandom_range(0, 7);
      if (tipo < 5) alvo = 32'($urandom_range(0, 255)) * 32'd4;
      else if (tipo == 5) alvo = 32'($urandom_range(240, 255)) * 32'd4;
      else if (tipo == 6) alvo = {$urandom_range(0, 1023), 2'b00} | 32'($urandom_range(1, 3));
      else alvo = 32'd1024 + 32'($urandom_range(0, 100000)) * 32'd4;
      passo("rand", st, rd, alvo);
    end

    // Asynchronous reset mid-run at pc 0x20
    passo("pre_rst", 1'b0, 1'b1, 32'h18);
    passo("pre_rst", 1'b0, 1'b0, 32'h0);
    passo("pre_rst", 1'b0, 1'b0, 32'h0);
    chk("pre_rst.pc20", pc_out, 32'h20);
    #2;
    reset = 1'b1;
    #1;
    modelo_reset();
    confere("rst_async");
    @(negedge clock);
    reset = 1'b0;
    passo("pos_rst_bolha", 1'b0, 1'b0, 32'h0);
    passo("pos_rst_fetch", 1'b0, 1'b0, 32'h0);
    passo("pos_rst_fetch", 1'b0, 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
